// File: rtl/eth_rx_frame_writer_pkg.sv
// Shared types for the EthCore RX frame writer: FSM states, the committed-frame
// descriptor and a saturating counter helper.
package eth_rx_pkg;

  // Descriptor fields are sized for the widest supported configuration
  // (2 KiB buffer, 16-bit length).
  localparam int DESC_START_W = 11;
  localparam int DESC_LEN_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DROP
  } state_e;

  typedef struct packed {
    logic [DESC_START_W-1:0] start;
    logic [DESC_LEN_W-1:0]   len;
  } desc_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
    return (en && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
  endfunction

endpackage

// File: rtl/eth_rx_frame_writer.sv
// Writes RX MAC frames into a circular frame RAM through port A; commits clean
// frames with a descriptor and rolls back bad, runt, oversized or overflowing ones.
module eth_rx_frame_writer
  import eth_rx_pkg::*;
#(
  parameter int pWIDTH_ADDR = DESC_START_W,
  parameter int pWIDTH_DATA = 8,
  parameter int pMIN_LEN    = 60,
  parameter int pMAX_LEN    = 1518,
  parameter int pWIDTH_LEN  = DESC_LEN_W
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   s_valid,
  input  logic [pWIDTH_DATA-1:0] s_data,
  input  logic                   s_sof,
  input  logic                   s_eof,
  input  logic                   s_err,
  output logic [pWIDTH_ADDR-1:0] mem_addr,
  output logic                   mem_wrena,
  output logic [pWIDTH_DATA-1:0] mem_idata,
  output logic                   mem_clkena,
  input  logic [pWIDTH_ADDR:0]   rd_ptr,
  output logic                   desc_valid,
  input  logic                   desc_ready,
  output logic [pWIDTH_ADDR-1:0] desc_start,
  output logic [pWIDTH_LEN-1:0]  desc_len,
  output logic [15:0]            cnt_frames,
  output logic [15:0]            cnt_drop_err,
  output logic [15:0]            cnt_drop_ovf
);

  localparam int PTR_W = pWIDTH_ADDR + 1;
  localparam logic [pWIDTH_LEN-1:0] MIN_LEN = pWIDTH_LEN'(pMIN_LEN);
  localparam logic [pWIDTH_LEN-1:0] MAX_LEN = pWIDTH_LEN'(pMAX_LEN);

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        wr_commit_q, wr_cur_q;
  logic [pWIDTH_LEN-1:0]   len_q;
  desc_t                   desc_q;
  logic                    desc_valid_q;
  logic [pWIDTH_ADDR-1:0]  mem_addr_q;
  logic [pWIDTH_DATA-1:0]  mem_idata_q;
  logic                    mem_wrena_q;
  logic [15:0]             cnt_frames_q, cnt_drop_err_q, cnt_drop_ovf_q;

  logic [PTR_W-1:0]        base, base_next, fill;
  logic [pWIDTH_LEN-1:0]   len_new;
  logic start_frame, in_frame, has_space, too_long, eof_bad;
  logic wr_ok, commit, drop_ovf, drop_err, drop_trunc;

  // Beat decode: every beat either writes, commits, or drops the frame it belongs to.
  always_comb begin
    start_frame = s_valid & s_sof;
    in_frame    = start_frame | (s_valid & (state_q == ST_WRITE));
    base        = start_frame ? wr_commit_q : wr_cur_q;
    base_next   = base + PTR_W'(1);
    len_new     = (start_frame ? '0 : len_q) + pWIDTH_LEN'(1);
    // Fill level below half the pointer range means the buffer has room.
    fill        = base - rd_ptr;
    has_space   = ~fill[PTR_W-1];
    too_long    = len_new > MAX_LEN;
    eof_bad     = s_err | (len_new < MIN_LEN) | (desc_valid_q & ~desc_ready);
    wr_ok       = in_frame & has_space & ~too_long;
    commit      = wr_ok & s_eof & ~eof_bad;
    drop_ovf    = in_frame & ~has_space;
    drop_err    = (in_frame & has_space & too_long) | (wr_ok & s_eof & eof_bad);
    drop_trunc  = start_frame & (state_q == ST_WRITE);
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    if (in_frame) begin
      if (s_eof)      state_d = ST_IDLE;
      else if (wr_ok) state_d = ST_WRITE;
      else            state_d = ST_DROP;
    end else if (s_valid && s_eof && state_q == ST_DROP) begin
      state_d = ST_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_commit_q    <= '0;
      wr_cur_q       <= '0;
      len_q          <= '0;
      desc_q         <= '0;
      desc_valid_q   <= 1'b0;
      mem_addr_q     <= '0;
      mem_idata_q    <= '0;
      mem_wrena_q    <= 1'b0;
      cnt_frames_q   <= '0;
      cnt_drop_err_q <= '0;
      cnt_drop_ovf_q <= '0;
    end else begin
      if (wr_ok && (!s_eof || commit)) wr_cur_q <= base_next;
      else if (in_frame)               wr_cur_q <= wr_commit_q;

      if (wr_ok) len_q <= len_new;

      if (commit) begin
        wr_commit_q  <= base_next;
        desc_q.start <= DESC_START_W'(wr_commit_q[pWIDTH_ADDR-1:0]);
        desc_q.len   <= DESC_LEN_W'(len_new);
      end
      desc_valid_q <= commit | (desc_valid_q & ~desc_ready);

      mem_wrena_q <= wr_ok;
      if (wr_ok) begin
        mem_addr_q  <= base[pWIDTH_ADDR-1:0];
        mem_idata_q <= s_data;
      end

      cnt_frames_q   <= sat_inc(cnt_frames_q, commit);
      cnt_drop_err_q <= sat_inc(sat_inc(cnt_drop_err_q, drop_trunc), drop_err);
      cnt_drop_ovf_q <= sat_inc(cnt_drop_ovf_q, drop_ovf);
    end
  end

  assign mem_clkena   = 1'b1;
  assign mem_addr     = mem_addr_q;
  assign mem_wrena    = mem_wrena_q;
  assign mem_idata    = mem_idata_q;
  assign desc_valid   = desc_valid_q;
  assign desc_start   = desc_q.start[pWIDTH_ADDR-1:0];
  assign desc_len     = desc_q.len[pWIDTH_LEN-1:0];
  assign cnt_frames   = cnt_frames_q;
  assign cnt_drop_err = cnt_drop_err_q;
  assign cnt_drop_ovf = cnt_drop_ovf_q;

endmodule

// File: tb/tb_eth_rx_frame_writer.sv
// Directed bench for eth_rx_frame_writer: a 2 KiB instance for the main flows and
// a 256-byte instance for buffer overflow and address wrap.
module tb_eth_rx_frame_writer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        s_valid, s_sof, s_eof, s_err;
  logic [7:0]  s_data;
  logic        desc_ready;
  logic [11:0] rd_ptr_a;
  logic [8:0]  rd_ptr_b;

  logic [10:0] mem_addr_a, desc_start_a;
  logic [7:0]  mem_addr_b, desc_start_b;
  logic [7:0]  mem_idata_a, mem_idata_b;
  logic        mem_wrena_a, mem_wrena_b, mem_clkena_a, mem_clkena_b;
  logic        desc_valid_a, desc_valid_b;
  logic [15:0] desc_len_a, desc_len_b;
  logic [15:0] cnt_frames_a, cnt_drop_err_a, cnt_drop_ovf_a;
  logic [15:0] cnt_frames_b, cnt_drop_err_b, cnt_drop_ovf_b;

  int n_pass   = 0;
  int n_checks = 0;

  eth_rx_frame_writer u_a (
    .clock(clock), .reset_n(reset_n),
    .s_valid(s_valid), .s_data(s_data), .s_sof(s_sof), .s_eof(s_eof), .s_err(s_err),
    .mem_addr(mem_addr_a), .mem_wrena(mem_wrena_a), .mem_idata(mem_idata_a),
    .mem_clkena(mem_clkena_a), .rd_ptr(rd_ptr_a),
    .desc_valid(desc_valid_a), .desc_ready(desc_ready),
    .desc_start(desc_start_a), .desc_len(desc_len_a),
    .cnt_frames(cnt_frames_a), .cnt_drop_err(cnt_drop_err_a), .cnt_drop_ovf(cnt_drop_ovf_a)
  );

  eth_rx_frame_writer #(.pWIDTH_ADDR(8)) u_b (
    .clock(clock), .reset_n(reset_n),
    .s_valid(s_valid), .s_data(s_data), .s_sof(s_sof), .s_eof(s_eof), .s_err(s_err),
    .mem_addr(mem_addr_b), .mem_wrena(mem_wrena_b), .mem_idata(mem_idata_b),
    .mem_clkena(mem_clkena_b), .rd_ptr(rd_ptr_b),
    .desc_valid(desc_valid_b), .desc_ready(desc_ready),
    .desc_start(desc_start_b), .desc_len(desc_len_b),
    .cnt_frames(cnt_frames_b), .cnt_drop_err(cnt_drop_err_b), .cnt_drop_ovf(cnt_drop_ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic idle_inputs();
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_sof   = 1'b0;
    s_eof   = 1'b0;
    s_err   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Sends n beats with data = beat index; when chk is set, verifies each registered
  // RAM write one cycle after its beat against the expected start address.
  task automatic send_frame(input int dut, input int n, input bit err, input bit eof_en,
                            input bit chk, input int start);
    logic [31:0] o_we, o_addr, o_data, e_addr;
    for (int i = 0; i <= n; i++) begin
      @(negedge clock);
      if (chk && i > 0) begin
        o_we   = dut != 0 ? 32'(mem_wrena_b) : 32'(mem_wrena_a);
        o_addr = dut != 0 ? 32'(mem_addr_b)  : 32'(mem_addr_a);
        o_data = dut != 0 ? 32'(mem_idata_b) : 32'(mem_idata_a);
        e_addr = 32'(start + i - 1) & (dut != 0 ? 32'h0FF : 32'h7FF);
        check("mem_wrena", o_we, 32'd1);
        check("mem_addr", o_addr, e_addr);
        check("mem_idata", o_data, 32'(i - 1) & 32'hFF);
      end
      if (i < n) begin
        s_valid = 1'b1;
        s_data  = 8'(i);
        s_sof   = (i == 0);
        s_eof   = eof_en && (i == n - 1);
        s_err   = err && (i == n - 1);
      end else begin
        idle_inputs();
      end
    end
  endtask

  task automatic accept_desc_a();
    @(negedge clock);
    desc_ready = 1'b1;
    @(negedge clock);
    desc_ready = 1'b0;
    check("desc_valid_after_accept", 32'(desc_valid_a), 32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    desc_ready = 1'b0;
    rd_ptr_a   = '0;
    rd_ptr_b   = '0;
    idle_inputs();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_desc_valid", 32'(desc_valid_a), 32'd0);
    check("rst_mem_wrena", 32'(mem_wrena_a), 32'd0);
    check("rst_mem_clkena", 32'(mem_clkena_a), 32'd1);
    check("rst_mem_clkena_b", 32'(mem_clkena_b), 32'd1);
    check("rst_cnt_frames", 32'(cnt_frames_a), 32'd0);
    check("rst_desc_len", 32'(desc_len_a), 32'd0);

    // Good 64-byte frame: data equals address.
    send_frame(0, 64, 1'b0, 1'b1, 1'b1, 0);
    check("good_desc_valid", 32'(desc_valid_a), 32'd1);
    check("good_desc_start", 32'(desc_start_a), 32'd0);
    check("good_desc_len", 32'(desc_len_a), 32'd64);
    check("good_cnt_frames", 32'(cnt_frames_a), 32'd1);
    accept_desc_a();

    // Errored frame rolls back; the next good frame reuses address 0.
    do_reset();
    send_frame(0, 64, 1'b1, 1'b1, 1'b0, 0);
    check("err_desc_valid", 32'(desc_valid_a), 32'd0);
    check("err_cnt_drop_err", 32'(cnt_drop_err_a), 32'd1);
    check("err_cnt_frames", 32'(cnt_frames_a), 32'd0);
    send_frame(0, 64, 1'b0, 1'b1, 1'b0, 0);
    check("rollback_desc_start", 32'(desc_start_a), 32'd0);
    check("rollback_desc_len", 32'(desc_len_a), 32'd64);
    accept_desc_a();

    // Runt and oversize dropped; exact min and max lengths accepted.
    do_reset();
    send_frame(0, 40, 1'b0, 1'b1, 1'b0, 0);
    send_frame(0, 1600, 1'b0, 1'b1, 1'b0, 0);
    check("len_cnt_drop_err", 32'(cnt_drop_err_a), 32'd2);
    check("len_desc_valid", 32'(desc_valid_a), 32'd0);
    check("len_cnt_frames", 32'(cnt_frames_a), 32'd0);
    check("len_cnt_drop_ovf", 32'(cnt_drop_ovf_a), 32'd0);
    send_frame(0, 60, 1'b0, 1'b1, 1'b0, 0);
    check("min_desc_start", 32'(desc_start_a), 32'd0);
    check("min_desc_len", 32'(desc_len_a), 32'd60);
    accept_desc_a();
    send_frame(0, 1518, 1'b0, 1'b1, 1'b0, 0);
    check("max_desc_start", 32'(desc_start_a), 32'd60);
    check("max_desc_len", 32'(desc_len_a), 32'd1518);
    check("max_cnt_frames", 32'(cnt_frames_a), 32'd2);
    accept_desc_a();

    // 256-byte buffer: overflow at byte 57, then wrap once the reader releases space.
    do_reset();
    desc_ready = 1'b1;
    send_frame(1, 200, 1'b0, 1'b1, 1'b0, 0);
    check("ovf_first_valid", 32'(desc_valid_b), 32'd1);
    check("ovf_first_start", 32'(desc_start_b), 32'd0);
    check("ovf_first_len", 32'(desc_len_b), 32'd200);
    send_frame(1, 100, 1'b0, 1'b1, 1'b0, 0);
    check("ovf_cnt_drop_ovf", 32'(cnt_drop_ovf_b), 32'd1);
    check("ovf_cnt_frames", 32'(cnt_frames_b), 32'd1);
    check("ovf_desc_valid", 32'(desc_valid_b), 32'd0);
    rd_ptr_b = 9'd200;
    send_frame(1, 100, 1'b0, 1'b1, 1'b1, 200);
    check("wrap_desc_valid", 32'(desc_valid_b), 32'd1);
    check("wrap_desc_start", 32'(desc_start_b), 32'd200);
    check("wrap_desc_len", 32'(desc_len_b), 32'd100);
    check("wrap_cnt_frames", 32'(cnt_frames_b), 32'd2);
    desc_ready = 1'b0;

    // Busy descriptor: second frame dropped, first descriptor held stable.
    do_reset();
    send_frame(0, 64, 1'b0, 1'b1, 1'b0, 0);
    check("busy_first_valid", 32'(desc_valid_a), 32'd1);
    send_frame(0, 64, 1'b0, 1'b1, 1'b0, 0);
    check("busy_cnt_drop_err", 32'(cnt_drop_err_a), 32'd1);
    check("busy_cnt_frames", 32'(cnt_frames_a), 32'd1);
    check("busy_desc_valid", 32'(desc_valid_a), 32'd1);
    check("busy_desc_start", 32'(desc_start_a), 32'd0);
    check("busy_desc_len", 32'(desc_len_a), 32'd64);
    accept_desc_a();

    // Asynchronous reset in the middle of a frame.
    send_frame(0, 20, 1'b0, 1'b0, 1'b0, 0);
    check("mid_mem_wrena", 32'(mem_wrena_a), 32'd1);
    check("mid_mem_addr", 32'(mem_addr_a), 32'd83);
    #2 reset_n = 1'b0;
    #1;
    check("arst_mem_wrena", 32'(mem_wrena_a), 32'd0);
    check("arst_mem_addr", 32'(mem_addr_a), 32'd0);
    check("arst_mem_idata", 32'(mem_idata_a), 32'd0);
    check("arst_cnt_frames", 32'(cnt_frames_a), 32'd0);
    check("arst_cnt_drop_err", 32'(cnt_drop_err_a), 32'd0);
    check("arst_desc_len", 32'(desc_len_a), 32'd0);
    check("arst_mem_clkena", 32'(mem_clkena_a), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    send_frame(0, 64, 1'b0, 1'b1, 1'b0, 0);
    check("post_rst_desc_valid", 32'(desc_valid_a), 32'd1);
    check("post_rst_desc_start", 32'(desc_start_a), 32'd0);
    check("post_rst_desc_len", 32'(desc_len_a), 32'd64);
    check("post_rst_cnt_frames", 32'(cnt_frames_a), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_rx_frame_writer.md
Name: eth_rx_frame_writer

Overview:
Receive-side stage directly upstream of the EthCore dual-port frame RAM. It takes the byte stream from the RX MAC and writes each frame into RAM port A, using the RAM as a circular buffer. When a frame ends cleanly, the block commits it and publishes a descriptor (start address, length) to the downstream reader on port B. Bad, oversized, runt or overflowing frames are rolled back, so the reader never sees them.

Parameters:
pWIDTH_ADDR, 11, RAM byte-address width; buffer holds 2**pWIDTH_ADDR bytes.
pWIDTH_DATA, 8, data width of the byte stream and RAM port A (fixed 8 in this revision).
pMIN_LEN, 60, minimum accepted frame length in bytes; shorter frames are dropped.
pMAX_LEN, 1518, maximum accepted frame length in bytes; longer frames are dropped.
pWIDTH_LEN, 16, width of desc_len.

Ports:
clock  in  1  single clock for everything (same domain as RAM clock_a).
reset_n  in  1  asynchronous active-low reset.
s_valid  in  1  byte beat valid. No backpressure: the MAC never stalls.
s_data  in  pWIDTH_DATA  byte payload.
s_sof  in  1  first byte of frame (qualified by s_valid).
s_eof  in  1  last byte of frame (qualified by s_valid). s_sof and s_eof on the same beat is legal.
s_err  in  1  frame error (FCS/PHY), sampled only on the eof beat.
mem_addr  out  pWIDTH_ADDR  RAM port A address.
mem_wrena  out  1  RAM port A write enable.
mem_idata  out  pWIDTH_DATA  RAM port A write data.
mem_clkena  out  1  RAM port A clock enable; tied 1.
rd_ptr  in  pWIDTH_ADDR+1  reader release pointer, with a wrap bit; the reader advances it past consumed frames.
desc_valid  out  1  descriptor available.
desc_ready  in  1  descriptor accepted when asserted together with desc_valid.
desc_start  out  pWIDTH_ADDR  RAM address of the frame's first byte.
desc_len  out  pWIDTH_LEN  frame length in bytes.
cnt_frames  out  16  committed frames, saturating.
cnt_drop_err  out  16  frames dropped for error, runt, oversize, truncation or busy descriptor; saturating.
cnt_drop_ovf  out  16  frames dropped for buffer overflow; saturating.

Behaviour:
- Reset values: all outputs 0 except mem_clkena=1. Internal wr_commit=0, wr_cur=0, state IDLE.
- Pointers: wr_commit and wr_cur are pWIDTH_ADDR+1 bits and wrap mod 2**(pWIDTH_ADDR+1). The RAM address is the low pWIDTH_ADDR bits.
- Space check: a byte may be written iff (wr_cur - rd_ptr) mod 2**(pWIDTH_ADDR+1) < 2**pWIDTH_ADDR.
- States: IDLE, WRITE, DROP.
- IDLE:
  - s_valid & s_sof: wr_cur = wr_commit; write the byte; len=1; go to WRITE. If this beat also has s_eof, evaluate EOF immediately.
  - Beats without sof are ignored.
- WRITE, on each s_valid beat:
  - Write the byte at wr_cur; wr_cur+1; len+1.
  - No space: no write; go to DROP; cnt_drop_ovf+1.
  - len would exceed pMAX_LEN: go to DROP; cnt_drop_err+1.
  - s_sof (truncated previous frame): drop the old frame (cnt_drop_err+1) and restart the new frame at wr_commit, as in IDLE.
- EOF evaluation. The frame is dropped (cnt_drop_err+1) if any of these hold:
  - s_err=1;
  - final len < pMIN_LEN;
  - desc_valid=1 and desc_ready=0 in that same cycle.
  Otherwise commit.
- Commit: next cycle desc_valid=1, desc_start=wr_commit[low bits], desc_len=len; wr_commit=wr_cur; cnt_frames+1; go to IDLE.
- Drop: wr_cur discarded (rollback to wr_commit); go to IDLE.
- DROP: ignore beats until an s_eof beat (go to IDLE) or an s_sof beat (start new frame as in IDLE).
- Write latency: mem_addr/mem_wrena/mem_idata are registered one cycle after the accepted beat. mem_wrena is a single-cycle pulse per byte. Rolled-back bytes are still physically written but lie beyond wr_commit and are harmless.
- Descriptor handshake: desc_valid holds until desc_valid & desc_ready, then clears the next cycle. The fields are stable while desc_valid=1. A simultaneous clear-by-ready and a new commit in the same cycle loads the new descriptor (desc_valid stays 1).
- Counters saturate at 16'hFFFF.
- Reset mid-frame: all state returns to reset values; any partial frame is lost.

Decomposition:
- Package eth_rx_pkg: state enum (IDLE, WRITE, DROP); descriptor struct {start, len}; a saturating-increment function.
- No sub-module. Counters and the pointer space check are inline.

Test Plan:
- Reset, then a 64-byte good frame 0x00..0x3F: mem_addr 0..63 with data = address; desc_start=0, desc_len=64 one cycle after eof; cnt_frames=1.
- 64-byte frame with s_err on eof: no descriptor; cnt_drop_err=1. The next good frame gets desc_start=0 (rollback).
- 40-byte runt, then a 1600-byte frame: both dropped; cnt_drop_err=2; desc_valid stays 0.
- pWIDTH_ADDR=8, rd_ptr held 0, 200-byte frame then 100-byte frame:
  - first commits (start 0, len 200);
  - second overflows at byte 57, so cnt_drop_ovf=1;
  - set rd_ptr=200, resend the 100-byte frame: commits with start 200, and addresses wrap 255→0.
- Two good frames, desc_ready held 0: the second is dropped (cnt_drop_err+1) and the first descriptor stays stable. Then assert ready: handshake completes and desc_valid clears.
- reset_n pulsed low mid-frame: all outputs return to 0 asynchronously. A following good frame commits at desc_start=0.
